// File: rtl/regfile_mp_pkg.sv
// Shared constants and helpers for the multi-ported register file.
// Optional build macro: REGFILE_BYPASS_EN (write-to-read forwarding).
`ifndef XLEN
`define XLEN 32
`endif
`ifndef REG_IDX_WIDTH
`define REG_IDX_WIDTH 5
`endif
`ifndef REG_X0
`define REG_X0 0
`endif
`ifndef REG_X1
`define REG_X1 1
`endif
`ifndef RF_NRD
`define RF_NRD 2
`endif
`ifndef RF_NWR
`define RF_NWR 1
`endif

package regfile_mp_pkg;
    localparam int XLEN   = `XLEN;
    localparam int REG_X0 = `REG_X0;
    localparam int REG_X1 = `REG_X1;

    // Read-port configuration snapshot, handy for debug views of a lane.
    typedef struct packed {
        logic            en;
        logic            rdy;
        logic [XLEN-1:0] data;
    } rd_rsp_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: issue sets, writeback clears, flush wipes all.
`ifndef REG_IDX_WIDTH
`define REG_IDX_WIDTH 5
`endif
`ifndef RF_NWR
`define RF_NWR 1
`endif

module regfile_scoreboard
    import regfile_mp_pkg::*;
#(
    parameter int REG_NUM = 32,
    parameter int NWR     = `RF_NWR,
    parameter int IDX_W   = `REG_IDX_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           iss_en,
    input  logic [IDX_W-1:0]               iss_idx,
    input  logic [NWR-1:0]                 clr_en,
    input  logic [NWR-1:0][IDX_W-1:0]      clr_idx,
    input  logic                           flush,
    output logic [REG_NUM-1:0]             busy
);

    logic [REG_NUM-1:0] busy_nxt;

    // Clears first so a same-cycle issue (younger) overrides them.
    always_comb begin
        busy_nxt = busy;
        for (int k = 0; k < NWR; k++)
            if (clr_en[k]) busy_nxt[clr_idx[k]] = 1'b0;
        if (iss_en && iss_idx != '0) busy_nxt[iss_idx] = 1'b1;
        busy_nxt[REG_X0] = 1'b0;
        if (flush) busy_nxt = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) busy <= '0;
        else     busy <= busy_nxt;
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported integer register file with pending-write scoreboard and x1 tap.
// Optional build macro: REGFILE_BYPASS_EN forwards same-cycle writes to reads.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef REG_IDX_WIDTH
`define REG_IDX_WIDTH 5
`endif
`ifndef RF_NRD
`define RF_NRD 2
`endif
`ifndef RF_NWR
`define RF_NWR 1
`endif

module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int REG_NUM = 32,
    parameter int NRD     = `RF_NRD,
    parameter int NWR     = `RF_NWR,
    parameter int IDX_W   = `REG_IDX_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NWR-1:0]          wr_en_i,
    input  logic [NWR*IDX_W-1:0]    wr_idx_i,
    input  logic [NWR*XLEN-1:0]     wr_data_i,
    input  logic [NRD-1:0]          rd_en_i,
    input  logic [NRD*IDX_W-1:0]    rd_idx_i,
    output logic [NRD*XLEN-1:0]     rd_data_o,
    output logic [NRD-1:0]          rd_rdy_o,
    input  logic                    iss_en_i,
    input  logic [IDX_W-1:0]        iss_idx_i,
    input  logic                    flush_i,
    output logic [XLEN-1:0]         x1_data_o,
    output logic                    x1_busy_o
);

    logic [NWR-1:0][IDX_W-1:0] wr_idx;
    logic [NWR-1:0][XLEN-1:0]  wr_data;
    logic [NRD-1:0][IDX_W-1:0] rd_idx;
    logic [REG_NUM-1:0][XLEN-1:0] regs;
    logic [REG_NUM-1:0]        busy;

    assign wr_idx  = wr_idx_i;
    assign wr_data = wr_data_i;
    assign rd_idx  = rd_idx_i;

    // Ascending port order: the highest-numbered port lands last and wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs <= '0;
        end else begin
            for (int k = 0; k < NWR; k++)
                if (wr_en_i[k] && wr_idx[k] != '0) regs[wr_idx[k]] <= wr_data[k];
        end
    end

    regfile_scoreboard #(
        .REG_NUM (REG_NUM),
        .NWR     (NWR),
        .IDX_W   (IDX_W)
    ) u_sb (
        .clk     (clk),
        .rst     (rst),
        .iss_en  (iss_en_i),
        .iss_idx (iss_idx_i),
        .clr_en  (wr_en_i),
        .clr_idx (wr_idx),
        .flush   (flush_i),
        .busy    (busy)
    );

    for (genvar j = 0; j < NRD; j++) begin : g_rd
        rd_rsp_t rsp;
        always_comb begin
            rsp.en   = rd_en_i[j];
            rsp.data = regs[rd_idx[j]];
            rsp.rdy  = ~busy[rd_idx[j]];
`ifdef REGFILE_BYPASS_EN
            for (int k = 0; k < NWR; k++)
                if (wr_en_i[k] && wr_idx[k] != '0 && wr_idx[k] == rd_idx[j]) begin
                    rsp.data = wr_data[k];
                    rsp.rdy  = 1'b1;
                end
`endif
            if (!rsp.en || rd_idx[j] == '0) begin
                rsp.data = '0;
                rsp.rdy  = 1'b1;
            end
        end
        assign rd_data_o[j*XLEN +: XLEN] = rsp.data;
        assign rd_rdy_o[j]               = rsp.rdy;
    end

`ifdef REGFILE_BYPASS_EN
    always_comb begin
        x1_data_o = regs[REG_X1];
        x1_busy_o = busy[REG_X1];
        for (int k = 0; k < NWR; k++)
            if (wr_en_i[k] && wr_idx[k] == IDX_W'(REG_X1)) begin
                x1_data_o = wr_data[k];
                x1_busy_o = 1'b0;
            end
    end
`else
    assign x1_data_o = regs[REG_X1];
    assign x1_busy_o = busy[REG_X1];
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Directed-vector bench for regfile_mp with two write and two read ports.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef REG_IDX_WIDTH
`define REG_IDX_WIDTH 5
`endif

module tb_regfile_mp;
    localparam int NRD = 2;
    localparam int NWR = 2;
    localparam int IW  = `REG_IDX_WIDTH;
    localparam int XW  = `XLEN;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NWR-1:0]       wr_en;
    logic [NWR*IW-1:0]    wr_idx;
    logic [NWR*XW-1:0]    wr_data;
    logic [NRD-1:0]       rd_en;
    logic [NRD*IW-1:0]    rd_idx;
    logic [NRD*XW-1:0]    rd_data;
    logic [NRD-1:0]       rd_rdy;
    logic                 iss_en;
    logic [IW-1:0]        iss_idx;
    logic                 flush;
    logic [XW-1:0]        x1_data;
    logic                 x1_busy;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    regfile_mp #(.REG_NUM(32), .NRD(NRD), .NWR(NWR), .IDX_W(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_en),
        .wr_idx_i  (wr_idx),
        .wr_data_i (wr_data),
        .rd_en_i   (rd_en),
        .rd_idx_i  (rd_idx),
        .rd_data_o (rd_data),
        .rd_rdy_o  (rd_rdy),
        .iss_en_i  (iss_en),
        .iss_idx_i (iss_idx),
        .flush_i   (flush),
        .x1_data_o (x1_data),
        .x1_busy_o (x1_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    endtask

    task automatic wr(input int p, input logic [IW-1:0] idx, input logic [XW-1:0] d);
        wr_en[p]            = 1'b1;
        wr_idx[p*IW +: IW]  = idx;
        wr_data[p*XW +: XW] = d;
    endtask

    task automatic rd(input int p, input logic en, input logic [IW-1:0] idx);
        rd_en[p]           = en;
        rd_idx[p*IW +: IW] = idx;
    endtask

    function automatic logic [XW-1:0] rdat(input int p);
        return rd_data[p*XW +: XW];
    endfunction

    // Drive at negedge, let the edge fire, sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        wr_en = '0; iss_en = 1'b0; flush = 1'b0; rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_en = '0; wr_idx = '0; wr_data = '0;
        rd_en = '0; rd_idx = '0; iss_en = 1'b0; iss_idx = '0; flush = 1'b0;
        step();

        // Dirty the array and scoreboard, then reset with a competing write/issue.
        idle(); wr(0, 5, 32'h11); wr(1, 6, 32'h22); step();
        idle(); wr(0, 1, 32'h33); iss_en = 1'b1; iss_idx = 5; step();
        idle(); rst = 1'b1; wr(0, 2, 32'h44); iss_en = 1'b1; iss_idx = 6; step();
        idle(); rd(0, 1, 5); rd(1, 1, 2); #1;
        chk("rst_rd0", rdat(0), 0);
        chk("rst_rd1", rdat(1), 0);
        chk("rst_rdy", rd_rdy, 2'b11);
        chk("rst_x1d", x1_data, 0);
        chk("rst_x1b", x1_busy, 0);
        rd(0, 1, 6); #1;
        chk("rst_rdy6", rd_rdy[0], 1);

        idle(); wr(0, 5, 32'hDEADBEEF); step();
        idle(); rd(0, 1, 5); rd(1, 0, 5); #1;
        chk("wr_x5", rdat(0), 32'hDEADBEEF);
        chk("rden0_d", rdat(1), 0);
        chk("rden0_r", rd_rdy[1], 1);

        idle(); wr(0, 0, 32'h1234); step();
        idle(); rd(0, 1, 0); #1;
        chk("x0_d", rdat(0), 0);
        chk("x0_r", rd_rdy[0], 1);

        idle(); wr(0, 7, 32'h11); wr(1, 7, 32'h22); step();
        idle(); rd(0, 1, 7); #1;
        chk("conflict", rdat(0), 32'h22);

        idle(); wr(0, 10, 32'hAAA); wr(1, 11, 32'hBBB); step();
        idle(); rd(0, 1, 10); rd(1, 1, 11); #1;
        chk("dual_p0", rdat(0), 32'hAAA);
        chk("dual_p1", rdat(1), 32'hBBB);

        // Scoreboard set / clear / set-wins / flush.
        idle(); iss_en = 1'b1; iss_idx = 3; step();
        idle(); rd(0, 1, 3); #1;
        chk("iss_busy", rd_rdy[0], 0);
        wr(0, 3, 32'h55); step();
        idle(); #1;
        chk("wb_rdy", rd_rdy[0], 1);
        chk("wb_data", rdat(0), 32'h55);
        iss_en = 1'b1; iss_idx = 3; wr(1, 3, 32'h66); step();
        idle(); #1;
        chk("setwin_r", rd_rdy[0], 0);
        chk("setwin_d", rdat(0), 32'h66);
        iss_en = 1'b1; iss_idx = 4; flush = 1'b1; step();
        idle(); rd(1, 1, 4); #1;
        chk("flush_x4", rd_rdy[1], 1);
        chk("flush_x3", rd_rdy[0], 1);

        // Same-cycle write and read of a busy x9.
        idle(); wr(0, 9, 32'h1111); step();
        idle(); iss_en = 1'b1; iss_idx = 9; step();
        idle(); rd(0, 1, 9); wr(1, 9, 32'hA5A5); #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp_d", rdat(0), 32'hA5A5);
        chk("byp_r", rd_rdy[0], 1);
`else
        chk("nobyp_d", rdat(0), 32'h1111);
        chk("nobyp_r", rd_rdy[0], 0);
`endif
        step();
        idle(); #1;
        chk("x9_after_d", rdat(0), 32'hA5A5);
        chk("x9_after_r", rd_rdy[0], 1);

        // x1 tap is independent of rd_en.
        idle(); rd_en = '0; iss_en = 1'b1; iss_idx = 1; step();
        idle(); #1;
        chk("x1_busy", x1_busy, 1);
        wr(0, 1, 32'h8000_0010); #1;
`ifdef REGFILE_BYPASS_EN
        chk("x1_byp_d", x1_data, 32'h8000_0010);
        chk("x1_byp_b", x1_busy, 0);
`else
        chk("x1_old_d", x1_data, 0);
        chk("x1_old_b", x1_busy, 1);
`endif
        step();
        idle(); #1;
        chk("x1_data", x1_data, 32'h8000_0010);
        chk("x1_clr", x1_busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
